// File: rtl/display_hdmi_yuv_to_rgb.sv
// display_hdmi_yuv_to_rgb
// Converts a 16-bit 4:2:2 YCbCr stream (chroma alternating Cb/Cr, active-low
// syncs) back into RGB888 with active-high syncs.
//
// Processing steps:
//   - upsample the chroma to 4:4:4
//   - apply a BT.601 fixed-point matrix (Q10)
//   - round and clamp to 0..255
//
// Data, DE and both syncs leave exactly six registers after capture.
//
// Optional feature: define DISPLAY_YUV2RGB_FULL_RANGE_EN to use full-range
// BT.601 coefficients instead of the default limited-range set.
module display_hdmi_yuv_to_rgb #(
  parameter int FRAME_CNT_W = 12
) (
  input  logic                   iHdmiClk,
  input  logic                   iRst_n,
  input  logic                   iYuvVs,
  input  logic                   iYuvHs,
  input  logic                   iYuvDe,
  input  logic [15:0]            iv16YuvData,
  output logic [7:0]             ov8Red,
  output logic [7:0]             ov8Green,
  output logic [7:0]             ov8Blue,
  output logic                   oRgbVd,
  output logic                   oRgbVs,
  output logic                   oRgbHs,
  output logic [FRAME_CNT_W-1:0] ovFrameCnt
);

`ifdef DISPLAY_YUV2RGB_FULL_RANGE_EN
  localparam logic [8:0]         Y_OFS = 9'd0;
  localparam logic signed [20:0] K_Y   = 21'sd1024;
  localparam logic signed [20:0] K_RCR = 21'sd1436;
  localparam logic signed [20:0] K_GCB = 21'sd352;
  localparam logic signed [20:0] K_GCR = 21'sd731;
  localparam logic signed [20:0] K_BCB = 21'sd1815;
`else
  localparam logic [8:0]         Y_OFS = 9'd16;
  localparam logic signed [20:0] K_Y   = 21'sd1192;
  localparam logic signed [20:0] K_RCR = 21'sd1634;
  localparam logic signed [20:0] K_GCB = 21'sd401;
  localparam logic signed [20:0] K_GCR = 21'sd832;
  localparam logic signed [20:0] K_BCB = 21'sd2066;
`endif

  // Control bundle carried alongside the data: {de, vs, hs}, syncs active-high.
  logic [2:0] s2_ctl_reg, s3_ctl_reg, s4_ctl_reg, s5_ctl_reg;

  // S1 capture registers
  logic [7:0] s1_y_reg, s1_c_reg;
  logic       s1_de_reg, s1_vs_reg, s1_hs_reg, s1_phase_reg;
  logic       in_phase;

  // Chroma pairing state
  logic [7:0] held_cr_reg, cb_hold_reg;
  logic [7:0] pair_cb, pair_cr;

  // S2..S5 datapath
  logic [7:0]         s2_y_reg, s2_cb_reg, s2_cr_reg;
  logic signed [8:0]  s3_y_reg, s3_cb_reg, s3_cr_reg;
  logic signed [20:0] s4_ky_reg, s4_rcr_reg, s4_gcb_reg, s4_gcr_reg, s4_bcb_reg;
  logic signed [22:0] s5_r_reg, s5_g_reg, s5_b_reg;

  logic [FRAME_CNT_W-1:0] frame_cnt_reg;

  function automatic logic signed [20:0] sx21(input logic signed [8:0] v);
    sx21 = {{12{v[8]}}, v};
  endfunction

  function automatic logic signed [22:0] sx23(input logic signed [20:0] v);
    sx23 = {{2{v[20]}}, v};
  endfunction

  // Round to nearest (add half an LSB of Q10), then saturate to 8 bits.
  function automatic logic [7:0] clamp8(input logic signed [22:0] v);
    logic signed [22:0] t;
    t = (v + 23'sd512) >>> 10;
    if (t < 0)
      clamp8 = 8'd0;
    else if (t > 23'sd255)
      clamp8 = 8'hFF;
    else
      clamp8 = t[7:0];
  endfunction

  // Phase of the word on the input bus.
  // It is odd only when it directly follows an even DE word.
  assign in_phase = iYuvDe & s1_de_reg & ~s1_phase_reg;

  // S1: register the inputs, invert syncs to active-high, tag the chroma phase.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      s1_y_reg     <= 8'd0;
      s1_c_reg     <= 8'd0;
      s1_de_reg    <= 1'b0;
      s1_vs_reg    <= 1'b0;
      s1_hs_reg    <= 1'b0;
      s1_phase_reg <= 1'b0;
    end else begin
      s1_y_reg     <= iv16YuvData[7:0];
      s1_c_reg     <= iv16YuvData[15:8];
      s1_de_reg    <= iYuvDe;
      s1_vs_reg    <= ~iYuvVs;
      s1_hs_reg    <= ~iYuvHs;
      s1_phase_reg <= in_phase;
    end
  end

  // Update the held Cr and the held Cb.
  // Held Cr is preset to neutral at each DE start and follows every odd pixel.
  // Held Cb remembers the even pixel's Cb for its odd partner.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      held_cr_reg <= 8'd128;
      cb_hold_reg <= 8'd0;
    end else begin
      if (iYuvDe && !s1_de_reg)
        held_cr_reg <= 8'd128;
      else if (s1_de_reg && s1_phase_reg)
        held_cr_reg <= s1_c_reg;
      if (!s1_phase_reg)
        cb_hold_reg <= s1_c_reg;
    end
  end

  // Pair chroma for the pixel in S1.
  // An even pixel looks ahead to the next bus word for its Cr, or falls back
  // to the held Cr when that word does not exist.
  always_comb begin
    pair_cb = s1_c_reg;
    pair_cr = held_cr_reg;
    if (s1_phase_reg) begin
      pair_cb = cb_hold_reg;
      pair_cr = s1_c_reg;
    end else if (in_phase) begin
      pair_cr = iv16YuvData[15:8];
    end
  end

  // S2: register the 4:4:4 sample.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      s2_y_reg   <= 8'd0;
      s2_cb_reg  <= 8'd0;
      s2_cr_reg  <= 8'd0;
      s2_ctl_reg <= 3'd0;
    end else begin
      s2_y_reg   <= s1_y_reg;
      s2_cb_reg  <= pair_cb;
      s2_cr_reg  <= pair_cr;
      s2_ctl_reg <= {s1_de_reg, s1_vs_reg, s1_hs_reg};
    end
  end

  // S3: remove the black-level and chroma offsets (9-bit two's complement).
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      s3_y_reg   <= 9'sd0;
      s3_cb_reg  <= 9'sd0;
      s3_cr_reg  <= 9'sd0;
      s3_ctl_reg <= 3'd0;
    end else begin
      s3_y_reg   <= $signed({1'b0, s2_y_reg} - Y_OFS);
      s3_cb_reg  <= $signed({1'b0, s2_cb_reg} - 9'd128);
      s3_cr_reg  <= $signed({1'b0, s2_cr_reg} - 9'd128);
      s3_ctl_reg <= s2_ctl_reg;
    end
  end

  // S4: form the five Q10 matrix products.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      s4_ky_reg  <= 21'sd0;
      s4_rcr_reg <= 21'sd0;
      s4_gcb_reg <= 21'sd0;
      s4_gcr_reg <= 21'sd0;
      s4_bcb_reg <= 21'sd0;
      s4_ctl_reg <= 3'd0;
    end else begin
      s4_ky_reg  <= sx21(s3_y_reg) * K_Y;
      s4_rcr_reg <= sx21(s3_cr_reg) * K_RCR;
      s4_gcb_reg <= sx21(s3_cb_reg) * K_GCB;
      s4_gcr_reg <= sx21(s3_cr_reg) * K_GCR;
      s4_bcb_reg <= sx21(s3_cb_reg) * K_BCB;
      s4_ctl_reg <= s3_ctl_reg;
    end
  end

  // S5: sum the products into the R, G and B channels.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      s5_r_reg   <= 23'sd0;
      s5_g_reg   <= 23'sd0;
      s5_b_reg   <= 23'sd0;
      s5_ctl_reg <= 3'd0;
    end else begin
      s5_r_reg   <= sx23(s4_ky_reg) + sx23(s4_rcr_reg);
      s5_g_reg   <= sx23(s4_ky_reg) - sx23(s4_gcb_reg) - sx23(s4_gcr_reg);
      s5_b_reg   <= sx23(s4_ky_reg) + sx23(s4_bcb_reg);
      s5_ctl_reg <= s4_ctl_reg;
    end
  end

  // S6: round, clamp and register the outputs. Data updates every clock.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      ov8Red   <= 8'd0;
      ov8Green <= 8'd0;
      ov8Blue  <= 8'd0;
      oRgbVd   <= 1'b0;
      oRgbVs   <= 1'b0;
      oRgbHs   <= 1'b0;
    end else begin
      ov8Red   <= clamp8(s5_r_reg);
      ov8Green <= clamp8(s5_g_reg);
      ov8Blue  <= clamp8(s5_b_reg);
      oRgbVd   <= s5_ctl_reg[2];
      oRgbVs   <= s5_ctl_reg[1];
      oRgbHs   <= s5_ctl_reg[0];
    end
  end

  // Count the active (falling) edges of the input VS, independent of DE.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n)
      frame_cnt_reg <= '0;
    else if (!iYuvVs && !s1_vs_reg)
      frame_cnt_reg <= frame_cnt_reg + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
  end

  assign ovFrameCnt = frame_cnt_reg;

endmodule

// File: tb/tb_display_hdmi_yuv_to_rgb.sv
// Bench for display_hdmi_yuv_to_rgb.
// Vectors run through a 6-deep history queue.
// The entry driven six negedges earlier is the one expected on the outputs now.
module tb_display_hdmi_yuv_to_rgb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs_n, hs_n, de;
  logic [15:0] data;
  logic [7:0]  r, g, b;
  logic        vd, vs, hs;
  logic [11:0] cnt;

  always #5 clk = ~clk;

  display_hdmi_yuv_to_rgb #(.FRAME_CNT_W(12)) dut (
    .iHdmiClk    (clk),
    .iRst_n      (rst_n),
    .iYuvVs      (vs_n),
    .iYuvHs      (hs_n),
    .iYuvDe      (de),
    .iv16YuvData (data),
    .ov8Red      (r),
    .ov8Green    (g),
    .ov8Blue     (b),
    .oRgbVd      (vd),
    .oRgbVs      (vs),
    .oRgbHs      (hs),
    .ovFrameCnt  (cnt)
  );

  typedef struct {
    logic        de;
    logic        vs_n;
    logic        hs_n;
    logic [15:0] data;
    logic        chk;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } vec_t;

`ifdef DISPLAY_YUV2RGB_FULL_RANGE_EN
  localparam logic [7:0] GREY_EXP = 8'd235;
`else
  localparam logic [7:0] GREY_EXP = 8'd255;
`endif
  localparam logic [15:0] IDLE_WORD = 16'h8010;
  localparam logic [15:0] GREY_WORD = 16'h80EB;

  vec_t tbl[$];
  vec_t hist[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pix = 0;

  function automatic vec_t mk(input logic de_i, input logic vs_i, input logic hs_i,
                              input logic [15:0] d, input logic chk_i,
                              input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    vec_t v;
    v.de = de_i; v.vs_n = vs_i; v.hs_n = hs_i; v.data = d;
    v.chk = chk_i; v.r = er; v.g = eg; v.b = eb;
    return v;
  endfunction

  function automatic vec_t px(input logic [15:0] d, input logic [7:0] er,
                              input logic [7:0] eg, input logic [7:0] eb);
    return mk(1'b1, 1'b1, 1'b1, d, 1'b1, er, eg, eb);
  endfunction

  function automatic vec_t idle();
    return mk(1'b0, 1'b1, 1'b1, IDLE_WORD, 1'b0, 8'd0, 8'd0, 8'd0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: check the entry driven 6 cycles ago, then drive this one.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    if (hist.size() >= 6) begin
      e = hist.pop_front();
      check("sync_de", {29'd0, vd, vs, hs}, {29'd0, e.de, ~e.vs_n, ~e.hs_n});
      if (e.chk) begin
        check("rgb", {8'd0, r, g, b}, {8'd0, e.r, e.g, e.b});
        $display("pixel %0d in=%h rgb=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                 n_pix, e.data, r, g, b, e.r, e.g, e.b);
        n_pix++;
      end
    end
    de   = v.de;
    vs_n = v.vs_n;
    hs_n = v.hs_n;
    data = v.data;
    hist.push_back(v);
  endtask

  // Hold reset, verify the cleared outputs, release with an idle bus.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_rgb", {8'd0, r, g, b}, 32'd0);
    check("rst_ctl", {29'd0, vd, vs, hs}, 32'd0);
    check("rst_cnt", {20'd0, cnt}, 32'd0);
    $display("reset released, outputs=(%0d,%0d,%0d) vd=%0b vs=%0b hs=%0b cnt=%0d",
             r, g, b, vd, vs, hs, cnt);
    rst_n = 1'b1;
    de = 1'b0; vs_n = 1'b1; hs_n = 1'b1; data = IDLE_WORD;
    hist.delete();
    for (int i = 0; i < 6; i++) hist.push_back(idle());
  endtask

  task automatic frame();
    repeat (3) step(mk(1'b0, 1'b0, 1'b1, IDLE_WORD, 1'b0, 8'd0, 8'd0, 8'd0));
    for (int ln = 0; ln < 2; ln++) begin
      repeat (2) step(mk(1'b0, 1'b1, 1'b0, IDLE_WORD, 1'b0, 8'd0, 8'd0, 8'd0));
      step(idle());
      repeat (4) step(px(GREY_WORD, GREY_EXP, GREY_EXP, GREY_EXP));
    end
  endtask

  initial begin
    rst_n = 1'b0; de = 1'b0; vs_n = 1'b1; hs_n = 1'b1; data = IDLE_WORD;

    tbl.push_back(idle());
    tbl.push_back(idle());
`ifdef DISPLAY_YUV2RGB_FULL_RANGE_EN
    repeat (2) tbl.push_back(px(16'h80C8, 8'd200, 8'd200, 8'd200));
    tbl.push_back(idle());
    repeat (2) tbl.push_back(px(16'h8000, 8'd0, 8'd0, 8'd0));
    tbl.push_back(idle());
    tbl.push_back(px(16'h5A51, 8'd238, 8'd14, 8'd14));
    tbl.push_back(px(16'hF051, 8'd238, 8'd14, 8'd14));
    tbl.push_back(idle());
    repeat (2) tbl.push_back(px(16'h80FF, 8'd255, 8'd255, 8'd255));
    tbl.push_back(idle());
`else
    repeat (8) tbl.push_back(px(16'h80EB, 8'd255, 8'd255, 8'd255));
    tbl.push_back(idle());
    repeat (4) tbl.push_back(px(16'h8010, 8'd0, 8'd0, 8'd0));
    tbl.push_back(idle());
    tbl.push_back(px(16'h5A51, 8'd254, 8'd0, 8'd0));
    tbl.push_back(px(16'hF051, 8'd254, 8'd0, 8'd0));
    tbl.push_back(idle());
    tbl.push_back(px(16'h4080, 8'd233, 8'd103, 8'd1));
    tbl.push_back(px(16'hC080, 8'd233, 8'd103, 8'd1));
    tbl.push_back(px(16'h3080, 8'd233, 8'd110, 8'd0));
    tbl.push_back(idle());
    tbl.push_back(px(16'h4080, 8'd130, 8'd155, 8'd1));
    tbl.push_back(idle());
    tbl.push_back(px(16'h80FF, 8'd255, 8'd175, 8'd255));
    tbl.push_back(px(16'hFFFF, 8'd255, 8'd175, 8'd255));
    tbl.push_back(idle());
    repeat (2) tbl.push_back(px(16'h8000, 8'd0, 8'd0, 8'd0));
    tbl.push_back(idle());
`endif

    do_reset(3);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    repeat (6) step(idle());

    // Four frames of active-low VS/HS with DE runs; DE falls as VS falls.
    for (int f = 0; f < 4; f++) frame();
    repeat (8) step(idle());
    check("frame_cnt", {20'd0, cnt}, 32'd4);
    $display("frame counter after 4 frames = %0d", cnt);

    // Reset in the middle of a line; nothing of that line may reappear.
    repeat (3) step(mk(1'b1, 1'b1, 1'b1, GREY_WORD, 1'b0, 8'd0, 8'd0, 8'd0));
    do_reset(1);
    repeat (10) step(idle());
    check("cnt_after_rst", {20'd0, cnt}, 32'd0);

    // The pipeline still works after the reset.
    repeat (2) step(px(GREY_WORD, GREY_EXP, GREY_EXP, GREY_EXP));
    repeat (7) step(idle());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
